dfi_log_writer: RTL and testbench
=================================

// Module: dfi_log_writer
// PURPOSE
//  Upstream producer for the DFI log checker. It buffers store events ({id, data}) from the
//  instrumentation tap and writes each one as an 8-byte entry into the circular log table in
//  memory. After each completed write it publishes the new write pointer with a one-cycle
//  trigger, which the checker latches as its log-address pointer.
// PARAMETERS
//  N_ADDR_WIDTH      32            address width of log table and pointers
//  N_DATA_WIDTH      32            event data width
//  N_LOGID_WIDTH     8             event/DFG-line id width
//  LOGTABLE_ADDRINIT 32'h1FEFFC00  first entry address of the log table
//  LOGTABLE_RANGE    32'h00000400  table size in bytes (multiple of 8)
//  FIFO_DEPTH        4             event buffer entries (power of 2, >=2)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  rst           in   1   asynchronous reset, active-high
//  i_evtValid    in   1   event offered
//  o_evtReady    out  1   buffer can accept; transfer = i_evtValid & o_evtReady at clk rise
//  i_evtId       in   8   event id (DFG line index)
//  i_evtData     in   32  event data (written value/address)
//  i_rdPtr       in   32  checker's current read address in the table
//  o_wrReq       out  1   memory write request, held until i_wrDone
//  o_wrAddr      out  32  byte address of entry being written
//  o_wrData      out  64  entry: {upper 24 bits, id[7:0], data[31:0]}
//  i_wrDone      in   1   write accepted by memory (single-cycle pulse)
//  o_trigger     out  1   one-cycle pulse: new pointer published
//  o_logAddrptr  out  32  write pointer after last completed write
//  o_tableFull   out  1   high while next write would reach i_rdPtr
// BEHAVIOUR
//  Reset: wrPtr=o_logAddrptr=LOGTABLE_ADDRINIT; o_wrReq=0, o_wrAddr=0, o_wrData=0,
//   o_trigger=0, o_tableFull=0, FIFO empty, o_evtReady=1, state=IDLE.
//  FIFO: o_evtReady = (count < FIFO_DEPTH), no bypass. Push and pop in same cycle keeps count;
//   push while full ignored (ready low). Order preserved.
//  nextPtr = (wrPtr >= LOGTABLE_ADDRINIT+LOGTABLE_RANGE-8) ? LOGTABLE_ADDRINIT : wrPtr+8.
//  o_tableFull = (nextPtr == i_rdPtr), combinational; wrPtr==i_rdPtr means table empty.
//  FSM:
//   IDLE:    FIFO non-empty & !o_tableFull -> WRITE; register o_wrAddr=wrPtr,
//            o_wrData=head entry, o_wrReq=1 (request visible 1 cycle after decision).
//   WRITE:   hold o_wrReq/o_wrAddr/o_wrData stable; on i_wrDone: pop FIFO, wrPtr<=nextPtr,
//            o_wrReq<=0 -> PUBLISH. i_wrDone ignored in any other state.
//   PUBLISH: o_trigger=1 for exactly this cycle, o_logAddrptr=new wrPtr -> IDLE.
//  Min event-to-trigger latency: 3 cycles + memory wait. Back-to-back entries: 3 cycles each
//   with i_wrDone in first WRITE cycle.
//  Table full: events keep filling FIFO; once FIFO full, o_evtReady=0 (stall, no drop).
//   Writing resumes the cycle after i_rdPtr moves so nextPtr != i_rdPtr.
//  Wrap: entry at INIT+RANGE-8 published pointer = INIT.
//  Reset mid-WRITE: o_wrReq drops asynchronously; pending entry and FIFO discarded.
//  Upper 24 bits of o_wrData are 0 unless feature below is enabled.
// CONFIGURATION
//  DFI_LOG_TIMESTAMP_EN defined: 24-bit free-running cycle counter (reset 0, wraps) sampled
//   at event push; stored with entry, emitted in o_wrData[63:40].
//  Not defined: counter absent, o_wrData[63:40]=0.
// TESTING
//  Single event id=8'h03 data=32'h1000 -> o_wrAddr=32'h1FEFFC00, o_wrData=64'h0000000300001000;
//   i_wrDone next cycle -> o_trigger 1 cycle, o_logAddrptr=32'h1FEFFC08.
//  128 events, i_rdPtr trailing -> 128th write at 32'h1FEFFFF8, o_logAddrptr wraps to 32'h1FEFFC00.
//  i_rdPtr=32'h1FEFFC08 with wrPtr=32'h1FEFFC00 -> o_tableFull=1, no o_wrReq; after 4 pushes
//   o_evtReady=0; i_rdPtr -> 32'h1FEFFC10 -> writing resumes, events in order.
//  i_wrDone delayed 5 cycles -> o_wrReq/o_wrAddr/o_wrData stable all 5 cycles, one trigger.
//  rst asserted while o_wrReq=1 -> o_wrReq=0 immediately; after release o_logAddrptr=32'h1FEFFC00,
//   FIFO empty.
//  DFI_LOG_TIMESTAMP_EN: push at counter 24'h000010 -> o_wrData[63:40]=24'h000010.

Source files
------------

// File: rtl/dfi_log_writer_if.sv
// Event/memory/pointer bundle between the DFI log writer and its environment.
// The master modport is the writer side; slave is the tap/memory/checker side.
interface dfi_log_writer_if #(
  parameter int N_ADDR_WIDTH  = 32,
  parameter int N_DATA_WIDTH  = 32,
  parameter int N_LOGID_WIDTH = 8
);
  logic                     evt_valid;
  logic                     evt_ready;
  logic [N_LOGID_WIDTH-1:0] evt_id;
  logic [N_DATA_WIDTH-1:0]  evt_data;
  logic [N_ADDR_WIDTH-1:0]  rd_ptr;
  logic                     wr_req;
  logic [N_ADDR_WIDTH-1:0]  wr_addr;
  logic [63:0]              wr_data;
  logic                     wr_done;
  logic                     trigger;
  logic [N_ADDR_WIDTH-1:0]  log_addrptr;
  logic                     table_full;

  modport master (
    input  evt_valid, evt_id, evt_data, rd_ptr, wr_done,
    output evt_ready, wr_req, wr_addr, wr_data, trigger, log_addrptr, table_full
  );

  modport slave (
    output evt_valid, evt_id, evt_data, rd_ptr, wr_done,
    input  evt_ready, wr_req, wr_addr, wr_data, trigger, log_addrptr, table_full
  );
endinterface

// File: rtl/dfi_log_writer.sv
// Buffers store events and writes them as 8-byte entries into a circular log table,
// publishing the write pointer after each write. Optional macro: DFI_LOG_TIMESTAMP_EN.
module dfi_log_writer #(
  parameter int                      N_ADDR_WIDTH      = 32,
  parameter int                      N_DATA_WIDTH      = 32,
  parameter int                      N_LOGID_WIDTH     = 8,
  parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDRINIT = 32'h1FEFFC00,
  parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_RANGE    = 32'h00000400,
  parameter int                      FIFO_DEPTH        = 4
) (
  input logic              clk,
  input logic              rst,
  dfi_log_writer_if.master bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = N_LOGID_WIDTH + N_DATA_WIDTH;
  localparam int PAD_W   = 64 - ENTRY_W;

  typedef logic [N_ADDR_WIDTH-1:0] addr_t;
  localparam addr_t LAST_ENTRY = LOGTABLE_ADDRINIT + LOGTABLE_RANGE - addr_t'(8);

  typedef enum logic [1:0] {IDLE, WRITE, PUBLISH} state_t;
  state_t state, state_next;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_idx, rd_idx;
  logic [CNT_W-1:0]   count;
  logic               push, pop, load;
  logic [PAD_W-1:0]   head_pad;

  addr_t       wr_ptr, next_ptr, wr_addr_q, log_addrptr_q;
  logic        wr_req_q, trigger_q;
  logic [63:0] wr_data_q;

  assign bus.evt_ready = (count < CNT_W'(FIFO_DEPTH));
  assign push          = bus.evt_valid & bus.evt_ready;

  assign next_ptr       = (wr_ptr >= LAST_ENTRY) ? LOGTABLE_ADDRINIT : wr_ptr + addr_t'(8);
  assign bus.table_full = (next_ptr == bus.rd_ptr);

  assign bus.wr_req      = wr_req_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.trigger     = trigger_q;
  assign bus.log_addrptr = log_addrptr_q;

`ifdef DFI_LOG_TIMESTAMP_EN
  // Free-running cycle stamp, captured alongside each event at push time.
  logic [PAD_W-1:0] ts_cnt;
  logic [PAD_W-1:0] fifo_ts [FIFO_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + PAD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_ts[wr_idx] <= ts_cnt;
  end

  assign head_pad = fifo_ts[rd_idx];
`else
  assign head_pad = '0;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= {bus.evt_id, bus.evt_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + PTR_W'(1);
      if (pop)  rd_idx <= rd_idx + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !bus.table_full) begin
          load       = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (bus.wr_done) begin
          pop        = 1'b1;
          state_next = PUBLISH;
        end
      end
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are latched at the IDLE decision and frozen until the write completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= LOGTABLE_ADDRINIT;
      log_addrptr_q <= LOGTABLE_ADDRINIT;
      wr_req_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      trigger_q     <= 1'b0;
    end else begin
      trigger_q <= 1'b0;
      if (load) begin
        wr_req_q  <= 1'b1;
        wr_addr_q <= wr_ptr;
        wr_data_q <= {head_pad, fifo_mem[rd_idx]};
      end
      if (pop) begin
        wr_req_q      <= 1'b0;
        wr_ptr        <= next_ptr;
        log_addrptr_q <= next_ptr;
        trigger_q     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dfi_log_writer.sv
// Directed/randomized bench for dfi_log_writer against a queue-and-slot-index reference model.
module tb_dfi_log_writer;
  localparam logic [31:0] INIT  = 32'h1FEFFC00;
  localparam logic [31:0] RANGE = 32'h00000400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dfi_log_writer_if bus ();
  dfi_log_writer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [23:0] ts;
    logic [7:0]  id;
    logic [31:0] data;
  } entry_t;

  entry_t      exp_q[$];
  int unsigned n_written;
  int unsigned tb_cycle;
  int          vectors     = 0;
  int          miscompares = 0;

  always @(posedge clk or posedge rst)
    if (rst) tb_cycle <= 0;
    else     tb_cycle <= tb_cycle + 1;

  // Expected entry address for the n-th write since reset.
  function automatic logic [31:0] slot(input int unsigned n);
    return INIT + ((n * 8) % RANGE);
  endfunction

  function automatic logic [23:0] ts_now();
`ifdef DFI_LOG_TIMESTAMP_EN
    logic [31:0] c;
    c = tb_cycle;
    return c[23:0];
`else
    return 24'h0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input logic [31:0] rdp);
    bus.evt_valid = 1'b0;
    bus.wr_done   = 1'b0;
    bus.rd_ptr    = rdp;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    n_written = 0;
  endtask

  task automatic push(input logic [7:0] id, input logic [31:0] data);
    int waited = 0;
    bus.evt_valid = 1'b1;
    bus.evt_id    = id;
    bus.evt_data  = data;
    while (!bus.evt_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!bus.evt_ready) check("push_ready_timeout", bus.evt_ready, 1);
    else begin
      exp_q.push_back({ts_now(), id, data});
      tick();
    end
    bus.evt_valid = 1'b0;
  endtask

  task automatic service(input int delay, output int lat, output logic [31:0] addr_seen);
    entry_t      e;
    logic [31:0] exp_ptr;
    logic [31:0] a;
    logic [63:0] d;
    lat = 0;
    addr_seen = 'x;
    while (!bus.wr_req && lat < 50) begin
      tick();
      lat++;
    end
    check("wr_req_seen", bus.wr_req, 1);
    if (!bus.wr_req) return;
    if (exp_q.size() == 0) begin
      check("unexpected_write", bus.wr_req, 0);
      return;
    end
    e       = exp_q.pop_front();
    exp_ptr = slot(n_written + 1);
    check("wr_addr", bus.wr_addr, slot(n_written));
    check("wr_data", bus.wr_data, e);
    a = bus.wr_addr;
    d = bus.wr_data;
    addr_seen = a;
    for (int i = 0; i < delay; i++) begin
      tick();
      check("hold_req", bus.wr_req, 1);
      check("hold_addr", bus.wr_addr, a);
      check("hold_data", bus.wr_data, d);
      check("no_early_trigger", bus.trigger, 0);
    end
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    n_written++;
    check("req_drop", bus.wr_req, 0);
    check("trigger_on", bus.trigger, 1);
    check("log_addrptr", bus.log_addrptr, exp_ptr);
    bus.rd_ptr = exp_ptr;  // checker consumes the new entry right away
    tick();
    check("trigger_off", bus.trigger, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] addr_seen, last_addr;

    bus.evt_valid = 1'b0;
    bus.evt_id    = '0;
    bus.evt_data  = '0;
    bus.rd_ptr    = INIT;
    bus.wr_done   = 1'b0;
    n_written     = 0;

    // Reset state
    tick();
    tick();
    check("rst_wr_req", bus.wr_req, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_trigger", bus.trigger, 0);
    check("rst_table_full", bus.table_full, 0);
    check("rst_evt_ready", bus.evt_ready, 1);
    check("rst_log_addrptr", bus.log_addrptr, INIT);
    rst = 1'b0;
    tick();
    check("idle_wr_req", bus.wr_req, 0);

    // Single directed event
    push(8'h03, 32'h0000_1000);
    service(0, lat, addr_seen);
    check("single_addr", addr_seen, 32'h1FEFFC00);
    check("single_ptr", bus.log_addrptr, 32'h1FEFFC08);
`ifndef DFI_LOG_TIMESTAMP_EN
    check("single_data", bus.wr_data, 64'h0000000300001000);
`endif

    // Slow memory: done after 5 cycles
    push(8'($urandom), $urandom);
    service(5, lat, addr_seen);
    check("slow_idle_req", bus.wr_req, 0);

    // Table full: stall, fill FIFO, then resume in order
    reset_dut(INIT + 32'd8);
    tick();
    check("full_flag", bus.table_full, 1);
    for (int i = 0; i < 4; i++) push(8'($urandom), $urandom);
    check("full_ready_low", bus.evt_ready, 0);
    bus.evt_valid = 1'b1;
    bus.evt_id    = 8'hEE;
    bus.evt_data  = $urandom;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("full_no_req", bus.wr_req, 0);
      check("full_still_ready_low", bus.evt_ready, 0);
    end
    bus.evt_valid = 1'b0;
    bus.rd_ptr    = INIT + 32'd16;
    for (int i = 0; i < 4; i++) begin
      service(0, lat, addr_seen);
      if (i > 0) check("full_b2b_gap", lat, 1);
    end
    check("full_drained_ready", bus.evt_ready, 1);

    // 128 random events with trailing reader: full lap, pointer wraps
    reset_dut(INIT);
    last_addr = '0;
    for (int g = 0; g < 32; g++) begin
      for (int i = 0; i < 4; i++) push(8'($urandom), $urandom);
      for (int i = 0; i < 4; i++) begin
        service(int'($urandom_range(0, 2)), lat, addr_seen);
        if (i > 0) check("b2b_gap", lat, 1);
        last_addr = addr_seen;
      end
      check("tbl_full_model", bus.table_full, slot(n_written + 1) == bus.rd_ptr);
    end
    check("wrap_last_addr", last_addr, 32'h1FEFFFF8);
    check("wrap_ptr", bus.log_addrptr, INIT);

`ifdef DFI_LOG_TIMESTAMP_EN
    reset_dut(INIT);
    while (tb_cycle < 16) tick();
    push(8'h5A, 32'hCAFE_0001);
    service(0, lat, addr_seen);
    check("ts_0x10", bus.wr_data[63:40], 24'h000010);
`endif

    // Asynchronous reset while a write is pending
    reset_dut(INIT);
    push(8'($urandom), $urandom);
    push(8'($urandom), $urandom);
    lat = 0;
    while (!bus.wr_req && lat < 50) begin
      tick();
      lat++;
    end
    check("pre_rst_req", bus.wr_req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_req_drop", bus.wr_req, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    n_written = 0;
    check("post_rst_ptr", bus.log_addrptr, INIT);
    check("post_rst_ready", bus.evt_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_req", bus.wr_req, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
